// File: rtl/data_memory_manager.sv
// Word-addressed data memory: four 64K-word regions, three RAM-backed banks
// plus a strobe-only region, with a two-stage registered read path.
module data_memory_manager #(
  parameter int unsigned BANK_AW = 16,
  parameter int unsigned DW      = 32
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [31:0]   address_i,
  input  logic [DW-1:0] data_i,
  input  logic          wren_i,
  output logic [DW-1:0] data_o,
  output logic [3:0]    wren,
  output logic [1:0]    sel
);

  localparam int unsigned NUM_BANKS = 3;
  localparam int unsigned DEPTH     = 1 << BANK_AW;
  localparam int unsigned REGION_W  = 2;

  // Address decode
  logic                in_range;
  logic [REGION_W-1:0] region;
  logic [BANK_AW-1:0]  offset;

  assign in_range = (address_i[31:18] == 14'd0);
  assign region   = address_i[17:16];
  assign offset   = address_i[BANK_AW-1:0];

  // One-hot write strobe, purely combinational
  always_comb begin
    wren = 4'b0000;
    if (in_range) begin
      wren[region] = wren_i;
    end
  end

  // Per-bank read data after stage 1
  logic [DW-1:0] bank_rdata [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port; storage is never reset, writes are blocked while in reset
    always_ff @(posedge CLK) begin
      if (RST_n && wren[b]) begin
        mem[offset] <= data_i;
      end
    end

    // Stage 1 read register; sampling before the write lands gives read-first
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= mem[offset];
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  // Stage 1 region tag; region 3 and out-of-range both read as zero
  logic [REGION_W-1:0] sel_d1;
  logic                zero_d1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sel_d1  <= '0;
      zero_d1 <= 1'b1;
    end else begin
      sel_d1  <= region;
      zero_d1 <= !in_range || (region == 2'd3);
    end
  end

  // Stage 2 bank select
  logic [DW-1:0] data_nxt;

  always_comb begin
    data_nxt = '0;
    if (!zero_d1) begin
      case (sel_d1)
        2'd0:    data_nxt = bank_rdata[0];
        2'd1:    data_nxt = bank_rdata[1];
        2'd2:    data_nxt = bank_rdata[2];
        default: data_nxt = '0;
      endcase
    end
  end

  // Stage 2 output register; sel always tags the word on data_o
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      data_o <= '0;
      sel    <= '0;
    end else begin
      data_o <= data_nxt;
      sel    <= sel_d1;
    end
  end

endmodule

// File: tb/tb_data_memory_manager.sv
// Directed self-checking bench for data_memory_manager.
module tb_data_memory_manager;

  logic        clk;
  logic        rst_n;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        wren_i;
  logic [31:0] data_o;
  logic [3:0]  wren;
  logic [1:0]  sel;

  int n_checks;
  int n_fail;

  data_memory_manager #(.BANK_AW(16), .DW(32)) dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .address_i (address_i),
    .data_i    (data_i),
    .wren_i    (wren_i),
    .data_o    (data_o),
    .wren      (wren),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; address_i = 32'h0; data_i = 32'h0; wren_i = 1'b0;
    #3;
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=%h", data_o, 32'h0); end
    n_checks++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_bank0();
    for (int i = 0; i < 15; i++) begin
      address_i = 32'(i); data_i = 32'(i); wren_i = 1'b1;
      step();
    end
    wren_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      address_i = 32'(i);
      step(); step();
      n_checks++;
      if (data_o !== 32'(i) || sel !== 2'd0) begin
        n_fail++; $display("FAIL bank0_read[%0d] got=%h sel=%0d exp=%h sel=0", i, data_o, sel, 32'(i));
      end
    end
  endtask

  task automatic test_banks12();
    for (int i = 0; i < 15; i++) begin
      wren_i = 1'b1;
      address_i = 32'h10000 + 32'(i); data_i = address_i; step();
      address_i = 32'h20000 + 32'(i); data_i = address_i; step();
    end
    wren_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      address_i = 32'h10000 + 32'(i);
      step(); step();
      n_checks++;
      if (data_o !== 32'h10000 + 32'(i) || sel !== 2'd1) begin
        n_fail++; $display("FAIL bank1_read[%0d] got=%h sel=%0d exp=%h sel=1", i, data_o, sel, 32'h10000 + 32'(i));
      end
      address_i = 32'h20000 + 32'(i);
      step(); step();
      n_checks++;
      if (data_o !== 32'h20000 + 32'(i) || sel !== 2'd2) begin
        n_fail++; $display("FAIL bank2_read[%0d] got=%h sel=%0d exp=%h sel=2", i, data_o, sel, 32'h20000 + 32'(i));
      end
      address_i = 32'(i);
      step(); step();
      n_checks++;
      if (data_o !== 32'(i) || sel !== 2'd0) begin
        n_fail++; $display("FAIL bank0_alias[%0d] got=%h sel=%0d exp=%h sel=0", i, data_o, sel, 32'(i));
      end
    end
  endtask

  task automatic test_strobe();
    address_i = 32'h0001_0005; data_i = 32'h0001_0005; wren_i = 1'b1;
    #1;
    n_checks++;
    if (wren !== 4'b0010) begin n_fail++; $display("FAIL strobe_r1 got=%b exp=0010", wren); end
    wren_i = 1'b0;
    #1;
    n_checks++;
    if (wren !== 4'b0000) begin n_fail++; $display("FAIL strobe_idle got=%b exp=0000", wren); end
    address_i = 32'h0003_0000; wren_i = 1'b1;
    #1;
    n_checks++;
    if (wren !== 4'b1000) begin n_fail++; $display("FAIL strobe_r3 got=%b exp=1000", wren); end
    step(); wren_i = 1'b0; step();
    n_checks++;
    if (data_o !== 32'h0 || sel !== 2'd3) begin
      n_fail++; $display("FAIL r3_read got=%h sel=%0d exp=0 sel=3", data_o, sel);
    end
    // Out-of-range write must not alias into bank 0 offset 0
    address_i = 32'h0004_0000; data_i = 32'h0000_0BAD; wren_i = 1'b1;
    #1;
    n_checks++;
    if (wren !== 4'b0000) begin n_fail++; $display("FAIL strobe_oor got=%b exp=0000", wren); end
    step(); wren_i = 1'b0; step();
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL oor_read got=%h exp=0", data_o); end
    address_i = 32'h0000_0005;
    step(); step();
    n_checks++;
    if (data_o !== 32'h5) begin n_fail++; $display("FAIL pre_oor_check got=%h exp=5", data_o); end
    address_i = 32'h0000_0000;
    step(); step();
    n_checks++;
    if (data_o !== 32'h0 || sel !== 2'd0) begin
      n_fail++; $display("FAIL oor_alias got=%h sel=%0d exp=0 sel=0", data_o, sel);
    end
  endtask

  task automatic test_back_to_back();
    wren_i = 1'b0;
    address_i = 32'h0000_0003; step();
    address_i = 32'h0001_0003; step();
    n_checks++;
    if (data_o !== 32'h3 || sel !== 2'd0) begin
      n_fail++; $display("FAIL b2b_0 got=%h sel=%0d exp=3 sel=0", data_o, sel);
    end
    address_i = 32'h0002_0003; step();
    n_checks++;
    if (data_o !== 32'h0001_0003 || sel !== 2'd1) begin
      n_fail++; $display("FAIL b2b_1 got=%h sel=%0d exp=10003 sel=1", data_o, sel);
    end
    step();
    n_checks++;
    if (data_o !== 32'h0002_0003 || sel !== 2'd2) begin
      n_fail++; $display("FAIL b2b_2 got=%h sel=%0d exp=20003 sel=2", data_o, sel);
    end
  endtask

  task automatic test_read_during_write();
    address_i = 32'h0000_0007; data_i = 32'h0000_DEAD; wren_i = 1'b1;
    step();
    wren_i = 1'b0;
    step();
    n_checks++;
    if (data_o !== 32'h7) begin n_fail++; $display("FAIL rdw_old got=%h exp=7", data_o); end
    step();
    n_checks++;
    if (data_o !== 32'h0000_DEAD) begin n_fail++; $display("FAIL rdw_new got=%h exp=dead", data_o); end
  endtask

  task automatic test_reset_mid();
    // data_o holds 0xDEAD here; reset must clear it without an edge
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (data_o !== 32'h0 || sel !== 2'd0) begin
      n_fail++; $display("FAIL midreset_async got=%h sel=%0d exp=0 sel=0", data_o, sel);
    end
    address_i = 32'h0000_0008; data_i = 32'h0000_BEEF; wren_i = 1'b1;
    step(); step();
    wren_i = 1'b0;
    address_i = 32'h0000_0007;
    #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL midreset_edge1 got=%h exp=0", data_o); end
    step();
    n_checks++;
    if (data_o !== 32'h0000_DEAD) begin n_fail++; $display("FAIL midreset_edge2 got=%h exp=dead", data_o); end
    address_i = 32'h0000_0008;
    step(); step();
    n_checks++;
    if (data_o !== 32'h8) begin n_fail++; $display("FAIL reset_write_blocked got=%h exp=8", data_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bank0();
    test_banks12();
    test_strobe();
    test_back_to_back();
    test_read_during_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
